scan_display_n: RTL and testbench

//  Parametrised N-digit multiplexed 7-segment scan driver; successor to the fixed 8-digit scanner.

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg7_hex_decode.sv | 13 +
 rtl/scan_display_n.sv | 113 +++++++++++
 tb/tb_scan_display_n.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment constants: the blank pattern and the active-low hex glyph table {a..g}.
package seg_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Index = hex value, bit 6 = segment a ... bit 0 = segment g, 0 = segment lit
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b0000001,  // 0
      7'b1001111,  // 1
      7'b0010010,  // 2
      7'b0000110,  // 3
      7'b1001100,  // 4
      7'b0100100,  // 5
      7'b0100000,  // 6
      7'b0001111,  // 7
      7'b0000000,  // 8
      7'b0000100,  // 9
      7'b0001000,  // A
      7'b1100000,  // B
      7'b0110001,  // C
      7'b1000010,  // D
      7'b0110000,  // E
      7'b0111000   // F
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      return SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment glyph {a,b,c,d,e,f,g}.
module seg7_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = hex_to_seg(nib);
   end

endmodule

// File: rtl/scan_display_n.sv
// N-digit multiplexed 7-segment scanner with per-digit dp/enable, anti-ghost blanking and
// frame-synchronous shadow latching. Optional build macro: DISPLAY_LZ_BLANK_EN (leading-zero blanking).
module scan_display_n
   import seg_pkg::*;
#(
   parameter  int N_DIGITS  = 8,
   parameter  int SLOT_CYC  = 16384,
   parameter  int BLANK_CYC = 64,
   localparam int IDX_W     = $clog2(N_DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*N_DIGITS-1:0] data,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   digit_en,
   output logic                  enable,
   output logic [IDX_W-1:0]      which,
   output logic [7:0]            seg,
   output logic                  frame_start
);

   localparam int               CNT_W    = $clog2(SLOT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      which_q, which_d;
   logic [4*N_DIGITS-1:0] data_sh_q, data_sh_d;
   logic [N_DIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic [N_DIGITS-1:0]   en_sh_q, en_sh_d;

   logic                  frame_first;
   logic                  show;
   logic [3:0]            nib_sh [N_DIGITS];
   logic [3:0]            nib_sel;
   logic [6:0]            seg_pat;
   logic [N_DIGITS-1:0]   lz_blank;

   assign frame_first = (which_q == '0) && (cnt_q == '0);

   always_comb begin
      cnt_d     = cnt_q + CNT_W'(1);
      which_d   = which_q;
      data_sh_d = data_sh_q;
      dp_sh_d   = dp_sh_q;
      en_sh_d   = en_sh_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         which_d = (which_q == IDX_LAST) ? '0 : which_q + IDX_W'(1);
      end
      // Inputs are sampled only once per frame so a frame never mixes old and new data
      if (frame_first) begin
         data_sh_d = data;
         dp_sh_d   = dp_in;
         en_sh_d   = digit_en;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         which_q   <= '0;
         data_sh_q <= '0;
         dp_sh_q   <= '0;
         en_sh_q   <= '0;
      end else begin
         cnt_q     <= cnt_d;
         which_q   <= which_d;
         data_sh_q <= data_sh_d;
         dp_sh_q   <= dp_sh_d;
         en_sh_q   <= en_sh_d;
      end
   end

   // Digit 0 sits in the most significant nibble
   always_comb begin
      for (int k = 0; k < N_DIGITS; k++) begin
         nib_sh[k] = data_sh_q[4*(N_DIGITS-1-k) +: 4];
      end
   end

`ifdef DISPLAY_LZ_BLANK_EN
   logic zero_run;

   // Prefix-AND of "nibble is zero" from the most significant digit; the last digit always shows
   always_comb begin
      zero_run = 1'b1;
      lz_blank = '0;
      for (int k = 0; k < N_DIGITS - 1; k++) begin
         zero_run    = zero_run & (nib_sh[k] == 4'h0);
         lz_blank[k] = zero_run;
      end
   end
`else
   assign lz_blank = '0;
`endif

   assign nib_sel = nib_sh[which_q];

   seg7_hex_decode u_dec (
      .nib   (nib_sel),
      .seg_n (seg_pat)
   );

   assign show        = (cnt_q >= CNT_SHOW);
   assign which       = which_q;
   assign enable      = show & en_sh_q[which_q] & ~lz_blank[which_q];
   assign seg         = enable ? {seg_pat, ~dp_sh_q[which_q]} : SEG_BLANK;
   // Counters sit at slot 0, cycle 0 while reset is held; the pulse must wait for release
   assign frame_start = frame_first & ~rst;

endmodule

// File: tb/tb_scan_display_n.sv
// Scoreboard bench for scan_display_n (N_DIGITS=8, SLOT_CYC=16, BLANK_CYC=4).
module tb_scan_display_n;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data;
   logic [7:0]  dp_in;
   logic [7:0]  digit_en;
   logic        enable;
   logic [2:0]  which;
   logic [7:0]  seg;
   logic        frame_start;

   scan_display_n #(
      .N_DIGITS  (8),
      .SLOT_CYC  (16),
      .BLANK_CYC (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .data        (data),
      .dp_in       (dp_in),
      .digit_en    (digit_en),
      .enable      (enable),
      .which       (which),
      .seg         (seg),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         at;
      logic       en;
      logic [7:0] sg;
      logic [2:0] wh;
      logic       fs;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   base  = 0;

`ifdef DISPLAY_LZ_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   task automatic push_abs(input int at, input logic en, input logic [7:0] sg,
                           input logic [2:0] wh, input logic fs, input string name);
      exp_t e;
      e.at = at; e.en = en; e.sg = sg; e.wh = wh; e.fs = fs; e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic push_t(input int t, input logic en, input logic [7:0] sg,
                         input logic [2:0] wh, input logic fs, input string name);
      push_abs(base + t, en, sg, wh, fs, name);
   endtask

   task automatic wait_t(input int t);
      while (cyc < base + t) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Monitor: compare the queued expectation for this cycle against the outputs
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
         total++;
         bad++;
         $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                  exp_q[0].name, exp_q[0].at, cyc);
         void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         total++;
         if (enable !== e.en || seg !== e.sg || which !== e.wh || frame_start !== e.fs) begin
            bad++;
            $display("FAIL %s: got en=%b seg=%h which=%0d fs=%b, want en=%b seg=%h which=%0d fs=%b",
                     e.name, enable, seg, which, frame_start, e.en, e.sg, e.wh, e.fs);
         end
      end
   end

   initial begin
      rst      = 1'b1;
      data     = 32'h0123_4567;
      dp_in    = 8'h00;
      digit_en = 8'hFF;

      repeat (2) @(posedge clk);
      #2;
      push_abs(cyc,     1'b0, 8'hFF, 3'd0, 1'b0, "reset_hold_a");
      push_abs(cyc + 1, 1'b0, 8'hFF, 3'd0, 1'b0, "reset_hold_b");
      wait_t(4);
      rst  = 1'b0;
      base = cyc;

      // Frame 0/1: 0123_4567, all digits enabled, no dp
      push_t(0,   1'b0, 8'hFF, 3'd0, 1'b1, "first_frame_start");
      push_t(1,   1'b0, 8'hFF, 3'd0, 1'b0, "slot0_blank_c1");
      push_t(3,   1'b0, 8'hFF, 3'd0, 1'b0, "slot0_blank_c3");
      push_t(4,   1'b1, 8'h03, 3'd0, 1'b0, "slot0_show_c4");
      push_t(15,  1'b1, 8'h03, 3'd0, 1'b0, "slot0_show_c15");
      push_t(16,  1'b0, 8'hFF, 3'd1, 1'b0, "slot1_blank");
      push_t(20,  1'b1, 8'h9F, 3'd1, 1'b0, "slot1_show");
      push_t(116, 1'b1, 8'h1F, 3'd7, 1'b0, "slot7_show");
      push_t(127, 1'b1, 8'h1F, 3'd7, 1'b0, "frame0_last");
      push_t(128, 1'b0, 8'hFF, 3'd0, 1'b1, "second_frame_start");
      push_t(188, 1'b1, 8'h0D, 3'd3, 1'b0, "f1_slot3_after_change");
      push_t(196, 1'b1, 8'h99, 3'd4, 1'b0, "f1_slot4_old_data");
      push_t(244, 1'b1, 8'h1F, 3'd7, 1'b0, "f1_slot7_old_data");

      wait_t(181);
      data = 32'hFFFF_FFFF;
      push_t(256, 1'b0, 8'hFF, 3'd0, 1'b1, "third_frame_start");
      push_t(260, 1'b1, 8'h71, 3'd0, 1'b0, "f2_slot0_F");
      push_t(372, 1'b1, 8'h71, 3'd7, 1'b0, "f2_slot7_F");

      wait_t(300);
      data     = 32'h0080_0000;
      dp_in    = 8'b0000_0100;
      digit_en = 8'hFE;
      push_t(388, 1'b0, 8'hFF, 3'd0, 1'b0, "f3_slot0_disabled");
      push_t(420, 1'b1, 8'h00, 3'd2, 1'b0, "f3_slot2_8_dp");
      push_t(500, 1'b1, 8'h03, 3'd7, 1'b0, "f3_slot7_zero");

      wait_t(450);
      data     = 32'h0000_0A05;
      dp_in    = 8'h00;
      digit_en = 8'hFF;
      push_t(516, !LZ, LZ ? 8'hFF : 8'h03, 3'd0, 1'b0, "f4_slot0_lead_zero");
      push_t(580, !LZ, LZ ? 8'hFF : 8'h03, 3'd4, 1'b0, "f4_slot4_lead_zero");
      push_t(596, 1'b1, 8'h11, 3'd5, 1'b0, "f4_slot5_A");
      push_t(612, 1'b1, 8'h03, 3'd6, 1'b0, "f4_slot6_inner_zero");
      push_t(628, 1'b1, 8'h49, 3'd7, 1'b0, "f4_slot7_5");

      wait_t(600);
      data = 32'h0000_0000;
      push_t(644, !LZ, LZ ? 8'hFF : 8'h03, 3'd0, 1'b0, "f5_slot0_all_zero");
      push_t(740, !LZ, LZ ? 8'hFF : 8'h03, 3'd6, 1'b0, "f5_slot6_all_zero");
      push_t(756, 1'b1, 8'h03, 3'd7, 1'b0, "f5_slot7_last_shown");

      wait_t(700);
      data = 32'h0123_4567;
      push_t(776, 1'b1, 8'h03, 3'd0, 1'b0, "f6_slot0");
      push_t(856, 1'b1, 8'h49, 3'd5, 1'b0, "f6_slot5_before_rst");
      push_t(857, 1'b0, 8'hFF, 3'd0, 1'b0, "midslot_reset_now");
      push_t(859, 1'b0, 8'hFF, 3'd0, 1'b0, "midslot_reset_held");

      wait_t(857);
      rst = 1'b1;
      wait_t(860);
      rst  = 1'b0;
      base = cyc;
      push_t(0,   1'b0, 8'hFF, 3'd0, 1'b1, "restart_frame_start");
      push_t(4,   1'b1, 8'h03, 3'd0, 1'b0, "restart_slot0");
      push_t(20,  1'b1, 8'h9F, 3'd1, 1'b0, "restart_slot1");
      push_t(128, 1'b0, 8'hFF, 3'd0, 1'b1, "restart_next_frame");

      wait_t(140);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL leftover: %0d expectations unchecked, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
